// File: rtl/cnn_conv_engine.sv
// cnn_conv_engine: streaming multi-channel KXxKY convolution with bias, shift, ReLU and saturation
module cnn_conv_engine #(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int CI     = 2,
  parameter int CO     = 3,
  parameter int IW     = 28,
  parameter int IH     = 28,
  parameter int STRIDE = 1,
  parameter int SHIFT  = 0,
  parameter int RELU   = 1,
  parameter int O_F_BW = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_clear,
  input  logic [CO*CI*KY*KX*W_BW-1:0]     i_cnn_weight,
  input  logic [CO*B_BW-1:0]              i_cnn_bias,
  input  logic                            i_in_valid,
  input  logic [CI*I_F_BW-1:0]            i_in_fmap,
  output logic                            o_ot_valid,
  output logic [CO*O_F_BW-1:0]            o_ot_fmap,
  output logic                            o_ot_last
);
  localparam int ACC_BW = I_F_BW + W_BW + 1 + $clog2(CI*KY*KX);
  localparam int SW = (ACC_BW > B_BW ? ACC_BW : B_BW) + 1;
  localparam int EW = SW > O_F_BW ? SW : O_F_BW + 1;
  localparam int CW = IW > 1 ? $clog2(IW) : 1;
  localparam int RW = IH > 1 ? $clog2(IH) : 1;
  localparam int LR = KY - 1 + ((IH - KY) / STRIDE) * STRIDE;
  localparam int LC = KX - 1 + ((IW - KX) / STRIDE) * STRIDE;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-O_F_BW+1){1'b0}}, {(O_F_BW-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic [CW-1:0] col, col_q;
  logic [RW-1:0] row;
  logic accept, qual, last_pos;
  logic acc_q, qual_q, last_q;
  logic [CI*I_F_BW-1:0] pix_q;
  logic [I_F_BW-1:0] lb [CI][KY-1][IW];
  logic [I_F_BW-1:0] win [CI][KY][KX];
  logic v1, l1, v2, l2;
  logic signed [ACC_BW-1:0] mac [CO];
  logic signed [ACC_BW-1:0] acc_r [CO];
  logic signed [EW-1:0] s [CO];
  logic [CO*O_F_BW-1:0] res;

  assign accept = i_in_valid & ~i_clear;
  assign qual = int'(row) >= KY - 1 && int'(col) >= KX - 1 &&
                (int'(row) - (KY - 1)) % STRIDE == 0 && (int'(col) - (KX - 1)) % STRIDE == 0;
  assign last_pos = int'(row) == LR && int'(col) == LC;

  // position counters and input capture; the qualify tag travels with the pixel
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      col <= '0;
      row <= '0;
      col_q <= '0;
      pix_q <= '0;
      acc_q <= 1'b0;
      qual_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc_q <= accept;
      qual_q <= qual;
      last_q <= qual & last_pos;
      if (accept) begin
        col_q <= col;
        pix_q <= i_in_fmap;
      end
      if (i_clear) begin
        col <= '0;
        row <= '0;
      end else if (i_in_valid) begin
        col <= col == CW'(IW - 1) ? '0 : col + 1'b1;
        if (col == CW'(IW - 1)) row <= row == RW'(IH - 1) ? '0 : row + 1'b1;
      end
    end

  // line buffers hold the previous KY-1 rows, indexed by column; never cleared
  always_ff @(posedge clk)
    if (acc_q)
      for (int c = 0; c < CI; c++) begin
        lb[c][0][col_q] <= pix_q[c*I_F_BW +: I_F_BW];
        for (int l = 1; l < KY - 1; l++) lb[c][l][col_q] <= lb[c][l-1][col_q];
      end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      win <= '{default: '0};
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= acc_q & qual_q & ~i_clear;
      l1 <= acc_q & last_q & ~i_clear;
      if (acc_q)
        for (int c = 0; c < CI; c++) begin
          for (int y = 0; y < KY; y++)
            for (int x = 0; x < KX - 1; x++) win[c][y][x] <= win[c][y][x+1];
          for (int y = 0; y < KY - 1; y++) win[c][y][KX-1] <= lb[c][KY-2-y][col_q];
          win[c][KY-1][KX-1] <= pix_q[c*I_F_BW +: I_F_BW];
        end
    end

  always_comb
    for (int o = 0; o < CO; o++) begin
      mac[o] = '0;
      for (int c = 0; c < CI; c++)
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX; x++)
            mac[o] = mac[o] + ACC_BW'($signed({1'b0, win[c][y][x]})) *
                     ACC_BW'($signed(i_cnn_weight[(((o*CI+c)*KY+y)*KX+x)*W_BW +: W_BW]));
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc_r <= '{default: '0};
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      acc_r <= mac;
      v2 <= v1 & ~i_clear;
      l2 <= l1 & ~i_clear;
    end

  // bias, floor shift, ReLU, then saturation, in that order
  always_comb begin
    res = '0;
    for (int o = 0; o < CO; o++) begin
      s[o] = (EW'(acc_r[o]) + EW'($signed(i_cnn_bias[o*B_BW +: B_BW]))) >>> SHIFT;
      res[o*O_F_BW +: O_F_BW] = (RELU != 0 && s[o] < 0) ? '0 :
                                s[o] > MAX_V ? MAX_V[O_F_BW-1:0] :
                                s[o] < MIN_V ? MIN_V[O_F_BW-1:0] : s[o][O_F_BW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_ot_valid <= 1'b0;
      o_ot_last <= 1'b0;
      o_ot_fmap <= '0;
    end else begin
      o_ot_valid <= v2 & ~i_clear;
      o_ot_last <= l2 & ~i_clear;
      if (v2 & ~i_clear) o_ot_fmap <= res;
    end
endmodule

// File: tb/tb_cnn_conv_engine.sv
// tb_cnn_conv_engine: randomized frames on three parameter sets, checked against an arithmetic window model
module tb_cnn_conv_engine;
  localparam int N = 3;
  typedef struct packed { logic [47:0] v; logic last; int cyc; } ent_t;

  logic clk = 0, reset_n = 0, i_clear = 0, i_in_valid = 0;
  logic [1199:0] i_cnn_weight = '0;
  logic [47:0] i_cnn_bias = '0;
  logic [15:0] i_in_fmap = '0;
  logic ov [N];
  logic ol [N];
  logic [47:0] ofm [N];
  int st [N] = '{1, 2, 1};
  int sh [N] = '{0, 0, 4};
  int rl [N] = '{1, 1, 0};
  int pix [28][28][2];
  int w [3][2][5][5];
  int b [3];
  ent_t exp_q [N][$];
  ent_t obs_q [N][$];
  int cyc = 0, checks = 0, errors = 0, t44 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int i = 0; i < N; i++) if (ov[i]) obs_q[i].push_back('{ofm[i], ol[i], cyc});

  cnn_conv_engine u0 (.clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_cnn_weight(i_cnn_weight),
    .i_cnn_bias(i_cnn_bias), .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap),
    .o_ot_valid(ov[0]), .o_ot_fmap(ofm[0]), .o_ot_last(ol[0]));
  cnn_conv_engine #(.STRIDE(2)) u1 (.clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_cnn_weight(i_cnn_weight),
    .i_cnn_bias(i_cnn_bias), .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap),
    .o_ot_valid(ov[1]), .o_ot_fmap(ofm[1]), .o_ot_last(ol[1]));
  cnn_conv_engine #(.SHIFT(4), .RELU(0)) u2 (.clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_cnn_weight(i_cnn_weight),
    .i_cnn_bias(i_cnn_bias), .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap),
    .o_ot_valid(ov[2]), .o_ot_fmap(ofm[2]), .o_ot_last(ol[2]));

  function automatic bit qual(int i, int r, int c);
    return r >= 4 && c >= 4 && (r - 4) % st[i] == 0 && (c - 4) % st[i] == 0;
  endfunction

  function automatic bit is_last(int i, int r, int c);
    int e = 4 + ((28 - 5) / st[i]) * st[i];
    return r == e && c == e;
  endfunction

  function automatic logic [15:0] golden(int i, int r, int c, int co);
    longint a = b[co];
    longint d = longint'(1) << sh[i];
    for (int ci = 0; ci < 2; ci++)
      for (int ky = 0; ky < 5; ky++)
        for (int kx = 0; kx < 5; kx++) a += pix[r-4+ky][c-4+kx][ci] * w[co][ci][ky][kx];
    a = a >= 0 ? a / d : -((-a + d - 1) / d);
    if (rl[i] != 0 && a < 0) a = 0;
    a = a > 32767 ? 32767 : a < -32768 ? -32768 : a;
    return 16'(a);
  endfunction

  task automatic pack_params;
    for (int co = 0; co < 3; co++) begin
      for (int ci = 0; ci < 2; ci++)
        for (int ky = 0; ky < 5; ky++)
          for (int kx = 0; kx < 5; kx++)
            i_cnn_weight[(((co*2+ci)*5+ky)*5+kx)*8 +: 8] = 8'(w[co][ci][ky][kx]);
      i_cnn_bias[co*16 +: 16] = 16'(b[co]);
    end
  endtask

  task automatic rand_all;
    foreach (pix[r, c, k]) pix[r][c][k] = int'($urandom_range(0, 255));
    foreach (w[o, k, y, x]) w[o][k][y][x] = int'($urandom_range(0, 255)) - 128;
    foreach (b[o]) b[o] = int'($urandom_range(0, 65535)) - 32768;
    pack_params;
  endtask

  task automatic start;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
    end
  endtask

  task automatic idle(int n);
    i_in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pixel(int r, int c);
    i_in_valid = 1;
    i_in_fmap = {8'(pix[r][c][1]), 8'(pix[r][c][0])};
    for (int i = 0; i < N; i++)
      if (qual(i, r, c))
        exp_q[i].push_back('{{golden(i, r, c, 2), golden(i, r, c, 1), golden(i, r, c, 0)}, is_last(i, r, c), cyc + 4});
    if (r == 4 && c == 4) t44 = cyc + 1;
    @(posedge clk);
    #1;
    i_in_valid = 0;
  endtask

  task automatic send_frame(bit gaps);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
        drive_pixel(r, c);
      end
  endtask

  task automatic test_reset;
    reset_n = 0;
    idle(3);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || ol[i] !== 1'b0 || ofm[i] !== '0) begin
        errors++;
        $display("FAIL reset u%0d: valid=%b last=%b fmap=%h, need 0 0 0", i, ov[i], ol[i], ofm[i]);
      end
    end
    reset_n = 1;
    idle(2);
  endtask

  task automatic test_ones;
    int nl;
    start;
    foreach (pix[r, c, k]) pix[r][c][k] = 1;
    foreach (w[o, k, y, x]) w[o][k][y][x] = 1;
    foreach (b[o]) b[o] = 0;
    pack_params;
    send_frame(0);
    idle(6);
    checks++;
    if (obs_q[0].size() !== 576) begin
      errors++;
      $display("FAIL ones_count: got %0d outputs, need 576", obs_q[0].size());
    end
    checks++;
    if (obs_q[0].size() == 0 || obs_q[0][0].v !== {3{16'd50}}) begin
      errors++;
      $display("FAIL ones_value: got %h, need %h", obs_q[0].size() ? obs_q[0][0].v : 48'h0, {3{16'd50}});
    end
    nl = 0;
    foreach (obs_q[0][k]) nl += int'(obs_q[0][k].last);
    checks++;
    if (nl !== 1 || obs_q[0].size() < 576 || obs_q[0][575].last !== 1'b1) begin
      errors++;
      $display("FAIL ones_last: got %0d last flags, need exactly 1 on output #576", nl);
    end
    checks++;
    if (obs_q[0].size() == 0 || obs_q[0][0].cyc !== t44 + 3) begin
      errors++;
      $display("FAIL ones_latency: first output in cycle %0d, need %0d", obs_q[0].size() ? obs_q[0][0].cyc : -1, t44 + 3);
    end
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL ones_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
  endtask

  task automatic test_ramp;
    start;
    rand_all;
    foreach (pix[r, c, k]) pix[r][c][k] = (r * 28 + c + k) % 256;
    send_frame(0);
    idle(6);
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL ramp_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
  endtask

  task automatic test_negative;
    start;
    foreach (pix[r, c, k]) pix[r][c][k] = 255;
    foreach (w[o, k, y, x]) w[o][k][y][x] = -128;
    foreach (b[o]) b[o] = 0;
    pack_params;
    send_frame(0);
    idle(6);
    checks++;
    if (obs_q[0].size() == 0 || obs_q[0][0].v !== 48'h0) begin
      errors++;
      $display("FAIL neg_relu: got %h, need 0", obs_q[0].size() ? obs_q[0][0].v : 48'hx);
    end
    checks++;
    if (obs_q[2].size() == 0 || obs_q[2][0].v !== {3{16'h8000}}) begin
      errors++;
      $display("FAIL neg_saturate: got %h, need %h", obs_q[2].size() ? obs_q[2][0].v : 48'hx, {3{16'h8000}});
    end
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL neg_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
    start;
    foreach (w[o, k, y, x]) w[o][k][y][x] = 0;
    foreach (b[o]) b[o] = -17;
    pack_params;
    send_frame(0);
    idle(6);
    checks++;
    if (obs_q[2].size() == 0 || obs_q[2][0].v !== {3{16'hfffe}}) begin
      errors++;
      $display("FAIL neg_floor_shift: got %h, need %h", obs_q[2].size() ? obs_q[2][0].v : 48'hx, {3{16'hfffe}});
    end
    checks++;
    if (obs_q[1].size() == 0 || obs_q[1][obs_q[1].size()-1].v !== 48'h0) begin
      errors++;
      $display("FAIL neg_small_relu: got %h, need 0", obs_q[1].size() ? obs_q[1][0].v : 48'hx);
    end
  endtask

  task automatic test_stride;
    start;
    rand_all;
    send_frame(0);
    foreach (pix[r, c, k]) pix[r][c][k] = int'($urandom_range(0, 255));
    send_frame(0);
    idle(6);
    checks++;
    if (obs_q[1].size() !== 288) begin
      errors++;
      $display("FAIL stride_count: got %0d outputs over two frames, need 288", obs_q[1].size());
    end
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL stride_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
  endtask

  task automatic test_gaps;
    start;
    rand_all;
    send_frame(1);
    idle(6);
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL gaps_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
  endtask

  task automatic test_clear;
    start;
    rand_all;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 28; c++) drive_pixel(r, c);
    for (int c = 0; c < 12; c++) drive_pixel(10, c);
    i_clear = 1;
    i_in_valid = 1;
    i_in_fmap = 16'($urandom);
    for (int i = 0; i < N; i++)
      while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].cyc > cyc) void'(exp_q[i].pop_back());
    @(posedge clk);
    #1;
    i_clear = 0;
    i_in_valid = 0;
    checks++;
    if ((ov[0] | ov[1] | ov[2]) !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush: valid=%b%b%b after clear, need 000", ov[2], ov[1], ov[0]);
    end
    foreach (pix[r, c, k]) pix[r][c][k] = int'($urandom_range(0, 255));
    send_frame(0);
    idle(6);
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL clear_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
  endtask

  task automatic test_async_reset;
    start;
    rand_all;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 28; c++) drive_pixel(r, c);
    for (int c = 0; c < 20; c++) drive_pixel(12, c);
    #2;
    reset_n = 0;
    for (int i = 0; i < N; i++)
      while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].cyc >= cyc) void'(exp_q[i].pop_back());
    #1;
    checks++;
    if ((ov[0] | ov[1] | ov[2]) !== 1'b0 || (ofm[0] | ofm[1] | ofm[2]) !== 48'h0) begin
      errors++;
      $display("FAIL areset_during: valid=%b%b%b fmap0=%h, need 000 and 0", ov[2], ov[1], ov[0], ofm[0]);
    end
    idle(2);
    reset_n = 1;
    #1;
    checks++;
    if ((ov[0] | ov[1] | ov[2]) !== 1'b0 || (ofm[0] | ofm[1] | ofm[2]) !== 48'h0) begin
      errors++;
      $display("FAIL areset_after: valid=%b%b%b fmap0=%h, need 000 and 0", ov[2], ov[1], ov[0], ofm[0]);
    end
    foreach (pix[r, c, k]) pix[r][c][k] = int'($urandom_range(0, 255));
    send_frame(0);
    idle(6);
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = obs_q[i].size() == exp_q[i].size() ? -1 : exp_q[i].size();
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) if (bad < 0 && obs_q[i][k] !== exp_q[i][k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL areset_golden u%0d: %0d of %0d outputs, first diff #%0d got %h need %h", i, obs_q[i].size(), exp_q[i].size(), bad, obs_q[i][bad], exp_q[i][bad]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ones;
    test_ramp;
    test_negative;
    test_stride;
    test_gaps;
    test_clear;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
